// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive buffer with error status and flow-control flags
//
// Purpose:
//   Buffers characters from the UART deserializer together with their 3-bit
//   receive status. The host pops the oldest entry onto registered outputs.
//   Occupancy flags and RTS are decoded from the registered count.
//
// Ports:
//   Clk           in   baud-domain clock, rising edge
//   Rst           in   synchronous active-high reset
//   Rx_Data       in   received character
//   Rx_Err        in   receiver status {frame, parity, break}
//   Rx_Valid      in   one-cycle strobe qualifying Rx_Data/Rx_Err
//   Pop_Data      in   host read strobe, one pop per high cycle
//   Data_Out      out  character of the last popped entry
//   Rx_Error      out  status bits of the last popped entry
//   Data_Rdy      out  one-cycle pulse after a successful pop
//   FIFO_Empty    out  count == 0
//   FIFO_Full     out  count >= entries/2 + 1
//   FIFO_Overflow out  count == entries; further pushes are dropped
//   RTS           out  !FIFO_Full

module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATA_BITS-1:0] Rx_Data,
  input  logic [2:0]           Rx_Err,
  input  logic                 Rx_Valid,
  input  logic                 Pop_Data,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic [2:0]           Rx_Error,
  output logic                 Data_Rdy,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow,
  output logic                 RTS
);

  localparam int FIFO_ENTRIES = 1 << FIFO_WIDTH;
  localparam int WORD_BITS    = DATA_BITS + 3;

  // Count thresholds, sized to the count register.
  localparam logic [FIFO_WIDTH:0] CNT_ONE  = {{FIFO_WIDTH{1'b0}}, 1'b1};
  localparam logic [FIFO_WIDTH:0] CNT_MAX  = {1'b1, {FIFO_WIDTH{1'b0}}};
  localparam logic [FIFO_WIDTH:0] CNT_FULL = {2'b01, {(FIFO_WIDTH-1){1'b0}}} + CNT_ONE;

  logic [WORD_BITS-1:0]  mem_q [FIFO_ENTRIES];

  logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_WIDTH:0]   count_q, count_d;
  logic [DATA_BITS-1:0]  data_out_q, data_out_d;
  logic [2:0]            rx_error_q, rx_error_d;
  logic                  data_rdy_q, data_rdy_d;

  logic                  push;
  logic                  pop;
  logic [WORD_BITS-1:0]  rd_word;

  // A pop at full frees a slot in the same cycle, so a simultaneous push is
  // still accepted. At empty the pop is ignored and the push lands normally.
  assign pop     = Pop_Data && (count_q != '0);
  assign push    = Rx_Valid && ((count_q < CNT_MAX) || pop);
  assign rd_word = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    rx_error_d = rx_error_q;
    data_rdy_d = pop;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = rd_word[DATA_BITS-1:0];
      rx_error_d = rd_word[WORD_BITS-1:DATA_BITS];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      rx_error_q <= '0;
      data_rdy_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      rx_error_q <= rx_error_d;
      data_rdy_q <= data_rdy_d;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge Clk) begin
    if (!Rst && push) begin
      mem_q[wr_ptr_q] <= {Rx_Err, Rx_Data};
    end
  end

  assign Data_Out      = data_out_q;
  assign Rx_Error      = rx_error_q;
  assign Data_Rdy      = data_rdy_q;
  assign FIFO_Empty    = (count_q == '0);
  assign FIFO_Full     = (count_q >= CNT_FULL);
  assign FIFO_Overflow = (count_q == CNT_MAX);
  assign RTS           = !FIFO_Full;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer of the UART, sitting directly downstream of the receiver/deserializer and upstream of the host read port. Stores each received character together with its 3-bit error status, presents the oldest entry on `Data_Out`/`Rx_Error` when the host strobes `Pop_Data`, and drives the `FIFO_Empty`, `FIFO_Full`, `FIFO_Overflow` and `RTS` flow-control flags. Capacity is `2**FIFO_WIDTH` entries.

## Interface
- `DATA_BITS`, 8, width of one received character
- `FIFO_WIDTH`, 8, address width; depth `FIFO_ENTRIES = 2**FIFO_WIDTH`
- `Clk` input 1 baud-domain clock; all logic on its rising edge
- `Rst` input 1 reset: one clock; reset is synchronous and active-high
- `Rx_Data` input DATA_BITS character from receiver
- `Rx_Err` input 3 receiver status: [0] break, [1] parity, [2] frame
- `Rx_Valid` input 1 one-cycle strobe: `Rx_Data`/`Rx_Err` valid
- `Pop_Data` input 1 host read strobe; each high cycle is one pop
- `Data_Out` output DATA_BITS registered character of the last popped entry
- `Rx_Error` output 3 registered error bits of the last popped entry
- `Data_Rdy` output 1 one-cycle pulse: `Data_Out`/`Rx_Error` just updated
- `FIFO_Empty` output 1 count == 0
- `FIFO_Full` output 1 count >= FIFO_ENTRIES/2 + 1
- `FIFO_Overflow` output 1 count == FIFO_ENTRIES; further pushes lost
- `RTS` output 1 ready-to-send to far end; equals `!FIFO_Full`

## Operation
- Storage: FIFO_ENTRIES words of DATA_BITS+3 bits {Rx_Err, Rx_Data}; write pointer, read pointer FIFO_WIDTH bits each (natural wrap at FIFO_ENTRIES-1 -> 0); occupancy `count` FIFO_WIDTH+1 bits, range 0..FIFO_ENTRIES.
- push = `Rx_Valid` && (count < FIFO_ENTRIES || pop). Push while count == FIFO_ENTRIES and no pop: word discarded, pointers/count unchanged.
- pop = `Pop_Data` && count != 0. Pop on empty: ignored, `Data_Out`, `Rx_Error` hold, no `Data_Rdy`.
- On pop: mem[rd_ptr] loaded into `Data_Out`/`Rx_Error`, rd_ptr+1, `Data_Rdy`=1 next cycle.
- count update: push only +1; pop only -1; both: unchanged (both pointers advance).
- Simultaneous push and pop at count==0: pop ignored, push accepted (no bypass; data visible only after a later pop).
- Flags are combinational decodes of registered `count`; `RTS` = `!FIFO_Full`. Upstream is expected to stop within the remaining FIFO_ENTRIES/2-1 slots.
- Error bits pass through unmodified; the FIFO never generates or clears them.

## Timing
- Reset (`Rst` high at a rising edge): pointers, count = 0; `Data_Out`=0, `Rx_Error`=0, `Data_Rdy`=0; hence `FIFO_Empty`=1, `FIFO_Full`=0, `FIFO_Overflow`=0, `RTS`=1. Reset mid-operation discards all stored entries; memory contents need not be cleared.
- `Rst` has priority over `Rx_Valid` and `Pop_Data` in the same cycle.
- Push at edge N: count and flags reflect it after edge N; entry poppable at edge N+1.
- Pop sampled at edge N: `Data_Out`/`Rx_Error` valid and `Data_Rdy`=1 after edge N; `Data_Rdy` drops after N+1 unless another pop. Host reads `Data_Out` any time after the pop cycle; value holds until next pop.
- Back-to-back pops every cycle allowed; each returns the next entry in order.

## Test plan
- Reset -> `FIFO_Empty`=1, `RTS`=1, `Data_Out`=0x00, `Rx_Error`=0; one `Pop_Data` cycle -> no `Data_Rdy`, outputs unchanged.
- Push 0x00..0xFF (256 strobes, err=0) -> `FIFO_Overflow`=1, `FIFO_Full`=1, `RTS`=0; 257th push 0x55 dropped; 256 pops return 0x00..0xFF in order, then `FIFO_Empty`=1, `FIFO_Overflow`=0.
- Push 128 entries -> `FIFO_Full`=0, `RTS`=1; 129th push -> `FIFO_Full`=1, `RTS`=0 next cycle; one pop -> `FIFO_Full`=0.
- Push 0xAA with `Rx_Err`=3'b010, 0x00 with 3'b001, 0xAA with 3'b100 -> pops return (0xAA,010),(0x00,001),(0xAA,100), `Data_Rdy` one cycle each.
- At count=256, assert `Rx_Valid`(0x5A) and `Pop_Data` same cycle -> count stays 256, popped entry is oldest, 0x5A becomes newest; at count=0, simultaneous push 0x11/pop -> count=1, no `Data_Rdy`, next pop returns 0x11.
- Fill to 200 with wrap (pre-advance pointers by 100 push/pop pairs), assert `Rst` mid-stream -> next cycle all reset values; subsequent push 0x3C/pop returns 0x3C.
